phase_select_ctrl: RTL

PHASE_SELECT_CTRL -- requirements
Module: phase_select_ctrl

---
 rtl/phase_select_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/phase_select_ctrl.sv
// Phase-select controller: integrates early/late detector votes and steps an
// 8:1 phase-mux select, with a post-step holdoff and a lock indicator.
module phase_select_ctrl #(
    parameter int VOTE_THRESH = 8,
    parameter int HOLDOFF     = 4,
    parameter int LOCK_COUNT  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] init_sel,
    input  logic       pd_valid,
    input  logic       early,
    input  logic       late,
    output logic [2:0] sel,
    output logic       sel_step,
    output logic       locked,
    output logic [1:0] state_dbg
);

    localparam int ACC_W = $clog2(VOTE_THRESH + 1) + 1;
    localparam int LCK_W = $clog2(LOCK_COUNT + 1);
    localparam int HLD_W = $clog2(HOLDOFF + 1);

    localparam logic signed [ACC_W-1:0] THRESH_POS = ACC_W'(VOTE_THRESH);
    localparam logic signed [ACC_W-1:0] THRESH_NEG = -ACC_W'(VOTE_THRESH);
    localparam logic [LCK_W-1:0]        LOCK_MAX   = LCK_W'(LOCK_COUNT);
    localparam logic [HLD_W-1:0]        HOLD_LOAD  = HLD_W'(HOLDOFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        HOLD  = 2'b10
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic [LCK_W-1:0]        lock_cnt;
    logic [LCK_W-1:0]        lock_next;
    logic [HLD_W-1:0]        hold_cnt;
    logic                    hit_up;
    logic                    hit_dn;

    assign state_dbg = state;

    // The stored accumulator never holds +/-VOTE_THRESH: a hit is acted on
    // in the same edge that would have stored it.
    always_comb begin
        acc_next = acc;
        if (pd_valid && late && !early) begin
            acc_next = acc + ACC_W'(1);
        end else if (pd_valid && early && !late) begin
            acc_next = acc - ACC_W'(1);
        end else begin
            acc_next = acc;
        end
        hit_up    = pd_valid && (acc_next == THRESH_POS);
        hit_dn    = pd_valid && (acc_next == THRESH_NEG);
        lock_next = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LCK_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 3'd0;
            acc      <= '0;
            lock_cnt <= '0;
            hold_cnt <= '0;
            sel_step <= 1'b0;
            locked   <= 1'b0;
        end else if (!enable) begin
            // Freeze sel and drop back to IDLE, abandoning any holdoff
            state    <= IDLE;
            acc      <= '0;
            lock_cnt <= '0;
            hold_cnt <= '0;
            sel_step <= 1'b0;
            locked   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sel      <= init_sel;
                    acc      <= '0;
                    lock_cnt <= '0;
                    sel_step <= 1'b0;
                    locked   <= 1'b0;
                    state    <= TRACK;
                end
                TRACK: begin
                    if (hit_up || hit_dn) begin
                        sel      <= hit_up ? sel + 3'd1 : sel - 3'd1;
                        sel_step <= 1'b1;
                        acc      <= '0;
                        lock_cnt <= '0;
                        locked   <= 1'b0;
                        hold_cnt <= HOLD_LOAD;
                        state    <= HOLD;
                    end else begin
                        sel_step <= 1'b0;
                        acc      <= acc_next;
                        locked   <= (lock_cnt == LOCK_MAX);
                        if (pd_valid) begin
                            lock_cnt <= lock_next;
                        end else begin
                            lock_cnt <= lock_cnt;
                        end
                    end
                end
                HOLD: begin
                    sel_step <= 1'b0;
                    acc      <= '0;
                    if (hold_cnt == '0) begin
                        state <= TRACK;
                    end else begin
                        hold_cnt <= hold_cnt - HLD_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    acc      <= '0;
                    lock_cnt <= '0;
                    sel_step <= 1'b0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule
